// File: rtl/mips_pkg.sv
// Shared MIPS field layout, format codes and opcode constants.
package mips_pkg;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_BAD = 2'd3;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;
    localparam int RD_MSB = 15;
    localparam int RD_LSB = 11;
    localparam int SH_MSB = 10;
    localparam int SH_LSB = 6;
    localparam int FN_MSB = 5;
    localparam int FN_LSB = 0;

    function automatic logic is_jump_op(input logic [5:0] op);
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/mips_instr_encoder_sync_fifo.sv
// First-word-fall-through synchronous FIFO with flush and occupancy count.
module sync_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 32,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head is forced to zero when empty so the output bus is clean after reset.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Packs R/I/J field descriptors into MIPS words and streams them via a FIFO.
// Define ENC_STATS_EN for per-format and rd-histogram statistics outputs.
import mips_pkg::*;

module mips_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_fmt,
    input  logic [5:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [5:0]       in_funct,
    input  logic [15:0]      in_imm,
    input  logic [25:0]      in_target,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] word_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             err
`ifdef ENC_STATS_EN
    ,
    output logic [CNT_W-1:0] r_cnt,
    output logic [CNT_W-1:0] i_cnt,
    output logic [CNT_W-1:0] j_cnt,
    output logic [3:0][3:0]  rd_hist
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   word;
    logic          legal;
    logic          accept;
    logic          push_word;
    logic          reject;
    logic [CW-1:0] count;
    logic          full;

    always_comb begin
        word  = '0;
        legal = 1'b0;
        unique case (in_fmt)
            FMT_R: begin
                word  = {OP_RTYPE, in_rs, in_rt, in_rd, in_shamt, in_funct};
                legal = 1'b1;
            end
            FMT_I: begin
                word  = {in_op, in_rs, in_rt, in_imm};
                legal = !((in_op == OP_RTYPE) || is_jump_op(in_op));
            end
            FMT_J: begin
                word  = {in_op, in_target};
                legal = is_jump_op(in_op);
            end
            default: begin
                word  = '0;
                legal = 1'b0;
            end
        endcase
    end

    assign full      = (count == CW'(DEPTH));
    assign in_ready  = !full && !flush;
    assign accept    = in_valid && in_ready;
    assign push_word = accept && legal;
    assign reject    = accept && !legal;
    assign out_valid = (count != '0);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push_word),
        .wdata (word),
        .pop   (out_valid && out_ready),
        .rdata (out_data),
        .count (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
            err_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            err <= reject;
            if (push_word) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
            if (reject) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ENC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            rd_hist <= '0;
        end else if (push_word) begin
            unique case (in_fmt)
                FMT_R:   r_cnt <= r_cnt + CNT_W'(1);
                FMT_I:   i_cnt <= i_cnt + CNT_W'(1);
                FMT_J:   j_cnt <= j_cnt + CNT_W'(1);
                default: ;
            endcase
            // Same rd slot the downstream classifier inspects, whatever the format.
            for (int k = 0; k < 4; k++) begin
                if (word[RD_MSB:RD_LSB] == 5'(k + 3)) begin
                    rd_hist[k] <= rd_hist[k] + 4'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed self-checking bench for mips_instr_encoder (DEPTH=4).
module tb_mips_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_fmt;
    logic [5:0]  in_op;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [15:0] word_cnt;
    logic [15:0] err_cnt;
    logic        err;
`ifdef ENC_STATS_EN
    logic [15:0]      r_cnt;
    logic [15:0]      i_cnt;
    logic [15:0]      j_cnt;
    logic [3:0][3:0]  rd_hist;
`endif

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int n_words = 0;
    logic [31:0] exp_q[$];

    mips_instr_encoder #(.DEPTH(4), .CNT_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_fmt    (in_fmt),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_funct  (in_funct),
        .in_imm    (in_imm),
        .in_target (in_target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt),
        .err_cnt   (err_cnt),
        .err       (err)
`ifdef ENC_STATS_EN
        ,
        .r_cnt     (r_cnt),
        .i_cnt     (i_cnt),
        .j_cnt     (j_cnt),
        .rd_hist   (rd_hist)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every word leaving the FIFO must match the next queued word.
    always @(negedge clk) begin
        if (rst_n && err) err_seen++;
        if (rst_n && out_valid && out_ready) begin
            check("q_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("out_word", out_data, exp_q.pop_front());
        end
    end

    task automatic push(input logic [1:0] f, input logic [5:0] op,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] imm,
                        input logic [25:0] tgt, input logic [31:0] exp,
                        input bit legal);
        in_fmt = f; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_funct = fn; in_imm = imm; in_target = tgt;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                if (legal) begin
                    exp_q.push_back(exp);
                    n_words++;
                end
                step();
                in_valid = 1'b0;
                return;
            end
            step();
        end
        check("push_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic push_r(input int i);
        push(2'd0, 6'h3F, 5'd0, 5'd0, 5'(i), 5'd0, 6'(i), 16'd0, 26'd0,
             (32'(i) << 11) | 32'(i), 1'b1);
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 100) begin
            step();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_fmt = '0; in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0;
        in_shamt = '0; in_funct = '0; in_imm = '0; in_target = '0;
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_word_cnt", 32'(word_cnt), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // R encode, one-cycle latency
        out_ready = 1'b0;
        push(2'd0, 6'h3F, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0,
             32'h00221820, 1'b1);
        check("r_valid", 32'(out_valid), 32'd1);
        check("r_data", out_data, 32'h00221820);
        check("r_word_cnt", 32'(word_cnt), 32'd1);
        out_ready = 1'b1;
        drain("r_drain");

        // I / J / JAL in order
        out_ready = 1'b0;
        push(2'd1, 6'd8, 5'd0, 5'd4, 5'd0, 5'd0, 6'd0, 16'd5, 26'd0,
             32'h20040005, 1'b1);
        push(2'd2, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0100000,
             32'h08100000, 1'b1);
        push(2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10,
             32'h0C000010, 1'b1);
        check("ij_head", out_data, 32'h20040005);
        out_ready = 1'b1;
        drain("ij_drain");
        check("ij_word_cnt", 32'(word_cnt), 32'd4);

        // illegal descriptors
        err_seen = 0;
        push(2'd1, 6'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'd1, 26'd0, 32'd0, 1'b0);
        push(2'd2, 6'd8, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd7, 32'd0, 1'b0);
        push(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 32'd0, 1'b0);
        step();
        step();
        check("ill_err_pulses", 32'(err_seen), 32'd3);
        check("ill_err_cnt", 32'(err_cnt), 32'd3);
        check("ill_word_cnt", 32'(word_cnt), 32'd4);
        check("ill_out_valid", 32'(out_valid), 32'd0);
        check("ill_err_low", 32'(err), 32'd0);

        // backpressure: fill, stall, drain, then admit the fifth
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_r(i);
        check("bp_full", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("bp_stable", out_data, 32'h00000801);
            step();
        end
        out_ready = 1'b1;
        push_r(5);
        drain("bp_drain");
        check("bp_word_cnt", 32'(word_cnt), 32'd9);

        // simultaneous push/pop at occupancy 2
        out_ready = 1'b0;
        push_r(10);
        push_r(11);
        out_ready = 1'b1;
        for (int i = 12; i < 32; i++) begin
            check("pp_ready", 32'(in_ready && out_valid), 32'd1);
            push_r(i);
        end
        drain("pp_drain");
        check("pp_word_cnt", 32'(word_cnt), 32'd31);

        // flush with three queued
        out_ready = 1'b0;
        push_r(1);
        push_r(2);
        push_r(3);
        flush = 1'b1;
        in_fmt = 2'd0; in_rd = 5'd9; in_valid = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_word_cnt", 32'(word_cnt), 32'd34);
        step();
        check("fl_still_empty", 32'(out_valid), 32'd0);

        // asynchronous reset mid-stream
        push_r(6);
        push_r(7);
        in_fmt = 2'd0; in_rd = 5'd8; in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(out_valid), 32'd0);
        check("ar_out_data", out_data, 32'd0);
        check("ar_word_cnt", 32'(word_cnt), 32'd0);
        check("ar_err_cnt", 32'(err_cnt), 32'd0);
        in_valid = 1'b0;
        exp_q.delete();
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        push(2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0,
             32'h00221820, 1'b1);
        drain("ar_drain");
        check("ar_word_cnt_after", 32'(word_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
